dsp_chain_2_fp16_operand_feeder: RTL

Operand issuer that drives a two-stage cascaded fp16 sum-of-products DSP chain, the transmit side of the chain's operand interface. It accepts one 8-operand fp16 vector per cycle over a valid/ready stream and drives stage-1 operands immediately and stage-2 operands `STAGE_SKEW` cycles later, so both halves of a vector meet in the cascade. It tracks each vector through the fixed chain latency to flag when the chain's `result` is valid, then flushes and signals batch completion. It sits between the operand buffers and the DSP chain instance.

---
 rtl/dsp_chain_2_fp16_operand_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dsp_chain_2_fp16_operand_feeder.sv
// Operand issuer for a two-stage cascaded fp16 sum-of-products DSP chain.
// Skews stage-2 operands and tracks each vector to the chain result.
module dsp_chain_2_fp16_operand_feeder #(
    parameter int STAGE_SKEW    = 1,
    parameter int CHAIN_LATENCY = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [127:0]     in_data,
    output logic [15:0]      top_a1,
    output logic [15:0]      top_b1,
    output logic [15:0]      bot_a1,
    output logic [15:0]      bot_b1,
    output logic [15:0]      top_a2,
    output logic [15:0]      top_b2,
    output logic [15:0]      bot_a2,
    output logic [15:0]      bot_b2,
    output logic             result_valid,
    output logic             result_last,
    output logic             done,
    output logic [CNT_W-1:0] vec_count
);

    localparam int D = STAGE_SKEW + CHAIN_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic                         r_ready;
    logic                         r_done;
    logic [CNT_W-1:0]             r_cnt;
    logic [63:0]                  r_s1;
    logic [STAGE_SKEW:0][63:0]    r_s2;
    logic [D:0]                   r_vp;
    logic [D:0]                   r_lp;
    logic                         w_acc;
    logic                         w_res_end;

    assign w_acc     = in_valid & r_ready;
    assign w_res_end = r_vp[D] & r_lp[D];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_vp    <= '0;
            r_lp    <= '0;
        end else begin
            // Bubbles enter as fp16 +0 so they add nothing downstream
            r_s1    <= w_acc ? in_data[63:0] : 64'h0;
            r_s2[0] <= w_acc ? in_data[127:64] : 64'h0;
            for (int i = 1; i <= STAGE_SKEW; i++) begin
                r_s2[i] <= r_s2[i-1];
            end
            r_vp <= {r_vp[D-1:0], w_acc};
            r_lp <= {r_lp[D-1:0], w_acc & in_last};

            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_cnt <= CNT_W'(1);
                        if (in_last) begin
                            r_state <= S_FLUSH;
                            r_ready <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (in_last) begin
                            r_state <= S_FLUSH;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_res_end) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_ready;
    assign done         = r_done;
    assign vec_count    = r_cnt;
    assign result_valid = r_vp[D];
    assign result_last  = r_lp[D];

    assign top_a1 = r_s1[15:0];
    assign top_b1 = r_s1[31:16];
    assign bot_a1 = r_s1[47:32];
    assign bot_b1 = r_s1[63:48];
    assign top_a2 = r_s2[STAGE_SKEW][15:0];
    assign top_b2 = r_s2[STAGE_SKEW][31:16];
    assign bot_a2 = r_s2[STAGE_SKEW][47:32];
    assign bot_b2 = r_s2[STAGE_SKEW][63:48];

endmodule
